// File: rtl/alu_arb_pkg.sv
// Shared types for the ALU arbiter: data word, ALU opcode, arbiter state
// and the latched operation record.
package alu_arb_pkg;

   localparam int WORD_W = 32;

   typedef logic [WORD_W-1:0] word_t;

   localparam word_t ZERO_WORD = '0;

   typedef enum logic [3:0] {
      alu_add  = 4'd0,
      alu_sub  = 4'd1,
      alu_and  = 4'd2,
      alu_or   = 4'd3,
      alu_xor  = 4'd4,
      alu_sll  = 4'd5,
      alu_srl  = 4'd6,
      alu_sra  = 4'd7,
      alu_slt  = 4'd8,
      alu_sltu = 4'd9
   } aluop_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } arb_state_e;

   typedef struct packed {
      word_t  data1;
      word_t  data2;
      aluop_t op;
   } alu_req_t;

   localparam alu_req_t ALU_REQ_RST = '{data1: ZERO_WORD, data2: ZERO_WORD, op: alu_add};

endpackage

// File: rtl/alu_rr_grant.sv
// Two-way grant: single valid always wins; ties go to the requester that
// was not granted last, or always to requester 0 in fixed-priority mode.
module alu_rr_grant #(
   parameter bit FIXED_PRIO = 1'b0
) (
   input  logic [1:0] i_valid,
   input  logic       i_last_grant,
   output logic [1:0] o_grant
);

   always_comb begin
      o_grant = 2'b00;
      case (i_valid)
         2'b01:   o_grant = 2'b01;
         2'b10:   o_grant = 2'b10;
         2'b11:   o_grant = (FIXED_PRIO || i_last_grant) ? 2'b01 : 2'b10;
         default: o_grant = 2'b00;
      endcase
   end

endmodule

// File: rtl/alu_arb.sv
// Arbitrates two requesters onto one shared ALU and holds the result until
// the owning requester consumes it.
//
//  state | meaning
//  ------+---------------------------------------------------------------
//  IDLE  | grant offered combinationally; accept latches op and owner
//  EXEC  | waiting for alu_busy_i low, then captures the ALU result
//  RESP  | result held for the owner until its rsp ready
module alu_arb
   import alu_arb_pkg::*;
#(
   parameter int FIXED_PRIO = 0
) (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   req0_valid_i,
   input  logic   req1_valid_i,
   output logic   req0_ready_o,
   output logic   req1_ready_o,
   input  word_t  req0_data1_i,
   input  word_t  req0_data2_i,
   input  word_t  req1_data1_i,
   input  word_t  req1_data2_i,
   input  aluop_t req0_op_i,
   input  aluop_t req1_op_i,
   output logic   rsp0_valid_o,
   output logic   rsp1_valid_o,
   input  logic   rsp0_ready_i,
   input  logic   rsp1_ready_i,
   output word_t  rsp_result_o,
   output word_t  alu_data1_o,
   output word_t  alu_data2_o,
   output aluop_t alu_op_o,
   input  word_t  alu_result_i,
   input  logic   alu_busy_i,
   output logic   arb_busy_o
);

   arb_state_e r_state;
   arb_state_e w_state_nxt;
   alu_req_t   r_req;
   alu_req_t   w_req_sel;
   word_t      r_result;
   logic       r_owner;
   logic       r_last_grant;
   logic [1:0] w_grant;
   logic [1:0] w_ready;
   logic [1:0] w_rsp_valid;
   logic [1:0] w_rsp_ready;
   logic       w_accept;
   logic       w_capture;

   alu_rr_grant #(
      .FIXED_PRIO (FIXED_PRIO != 0)
   ) u_grant (
      .i_valid      ({req1_valid_i, req0_valid_i}),
      .i_last_grant (r_last_grant),
      .o_grant      (w_grant)
   );

   assign w_rsp_ready = {rsp1_ready_i, rsp0_ready_i};

   always_comb begin
      w_req_sel = '{data1: req0_data1_i, data2: req0_data2_i, op: req0_op_i};
      if (w_grant[1]) begin
         w_req_sel = '{data1: req1_data1_i, data2: req1_data2_i, op: req1_op_i};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_ready     = 2'b00;
      w_rsp_valid = 2'b00;
      w_accept    = 1'b0;
      w_capture   = 1'b0;
      case (r_state)
         IDLE: begin
            w_ready = w_grant;
            if (|w_grant) begin
               w_accept    = 1'b1;
               w_state_nxt = EXEC;
            end
         end
         EXEC: begin
            if (!alu_busy_i) begin
               w_capture   = 1'b1;
               w_state_nxt = RESP;
            end
         end
         RESP: begin
            w_rsp_valid = r_owner ? 2'b10 : 2'b01;
            if (w_rsp_ready[r_owner]) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // owner and last_grant track the same accept but reset differently:
   // owner is 0, last_grant is 1 so requester 0 wins the first tie
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_req        <= ALU_REQ_RST;
         r_result     <= ZERO_WORD;
         r_owner      <= 1'b0;
         r_last_grant <= 1'b1;
      end else begin
         if (w_accept) begin
            r_req        <= w_req_sel;
            r_owner      <= w_grant[1];
            r_last_grant <= w_grant[1];
         end
         if (w_capture) begin
            r_result <= alu_result_i;
         end
      end
   end

   // handshake outputs are forced low while reset is asserted, so a valid
   // arriving during reset never sees a ready
   assign req0_ready_o = w_ready[0] & rst_n;
   assign req1_ready_o = w_ready[1] & rst_n;
   assign rsp0_valid_o = w_rsp_valid[0] & rst_n;
   assign rsp1_valid_o = w_rsp_valid[1] & rst_n;
   assign arb_busy_o   = (r_state != IDLE) & rst_n;

   assign rsp_result_o = r_result;
   assign alu_data1_o  = r_req.data1;
   assign alu_data2_o  = r_req.data2;
   assign alu_op_o     = r_req.op;

endmodule

// File: tb/tb_alu_arb.sv
// Directed bench for alu_arb: round-robin and fixed-priority instances share
// stimulus; each has its own behavioural ALU.
module tb_alu_arb;
   import alu_arb_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic   rst_n;
   logic   req0_valid, req1_valid;
   word_t  r0d1, r0d2, r1d1, r1d2;
   aluop_t r0op, r1op;
   logic   rsp0_ready, rsp1_ready, alu_busy;

   logic   rr_rdy0, rr_rdy1, rr_v0, rr_v1, rr_busy;
   word_t  rr_res, rr_a, rr_b, rr_alu_res;
   aluop_t rr_op;
   logic   fx_rdy0, fx_rdy1, fx_v0, fx_v1, fx_busy;
   word_t  fx_res, fx_a, fx_b, fx_alu_res;
   aluop_t fx_op;

   int n_cmp  = 0;
   int n_fail = 0;

   function automatic word_t alu_f(input word_t a, input word_t b, input aluop_t op);
      case (op)
         alu_add: return a + b;
         alu_sub: return a - b;
         alu_and: return a & b;
         alu_or:  return a | b;
         alu_xor: return a ^ b;
         default: return ZERO_WORD;
      endcase
   endfunction

   assign rr_alu_res = alu_f(rr_a, rr_b, rr_op);
   assign fx_alu_res = alu_f(fx_a, fx_b, fx_op);

   alu_arb #(.FIXED_PRIO(0)) u_rr (
      .clk(clk), .rst_n(rst_n),
      .req0_valid_i(req0_valid), .req1_valid_i(req1_valid),
      .req0_ready_o(rr_rdy0), .req1_ready_o(rr_rdy1),
      .req0_data1_i(r0d1), .req0_data2_i(r0d2),
      .req1_data1_i(r1d1), .req1_data2_i(r1d2),
      .req0_op_i(r0op), .req1_op_i(r1op),
      .rsp0_valid_o(rr_v0), .rsp1_valid_o(rr_v1),
      .rsp0_ready_i(rsp0_ready), .rsp1_ready_i(rsp1_ready),
      .rsp_result_o(rr_res),
      .alu_data1_o(rr_a), .alu_data2_o(rr_b), .alu_op_o(rr_op),
      .alu_result_i(rr_alu_res), .alu_busy_i(alu_busy),
      .arb_busy_o(rr_busy)
   );

   alu_arb #(.FIXED_PRIO(1)) u_fx (
      .clk(clk), .rst_n(rst_n),
      .req0_valid_i(req0_valid), .req1_valid_i(req1_valid),
      .req0_ready_o(fx_rdy0), .req1_ready_o(fx_rdy1),
      .req0_data1_i(r0d1), .req0_data2_i(r0d2),
      .req1_data1_i(r1d1), .req1_data2_i(r1d2),
      .req0_op_i(r0op), .req1_op_i(r1op),
      .rsp0_valid_o(fx_v0), .rsp1_valid_o(fx_v1),
      .rsp0_ready_i(rsp0_ready), .rsp1_ready_i(rsp1_ready),
      .rsp_result_o(fx_res),
      .alu_data1_o(fx_a), .alu_data2_o(fx_b), .alu_op_o(fx_op),
      .alu_result_i(fx_alu_res), .alu_busy_i(alu_busy),
      .arb_busy_o(fx_busy)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chkw(input string tag, input word_t obs, input word_t exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n      = 1'b0;
      req0_valid = 1'b1;
      req1_valid = 1'b0;
      r0d1 = 32'd0; r0d2 = 32'd0; r1d1 = 32'd0; r1d2 = 32'd0;
      r0op = alu_add; r1op = alu_add;
      rsp0_ready = 1'b0; rsp1_ready = 1'b0; alu_busy = 1'b0;

      // reset state, with a valid present during reset
      step();
      step();
      chk1("rst_ready0", rr_rdy0, 1'b0);
      chk1("rst_rsp0_valid", rr_v0, 1'b0);
      chk1("rst_busy", rr_busy, 1'b0);
      chkw("rst_result", rr_res, 32'd0);
      chkw("rst_alu_op", 32'(rr_op), 32'(alu_add));
      chkw("rst_alu_data1", rr_a, 32'd0);
      req0_valid = 1'b0;
      rst_n = 1'b1;
      step();
      chk1("post_rst_busy", rr_busy, 1'b0);

      // ties: 1+1 and 9-4, both held, responses consumed at once
      r0d1 = 32'd1; r0d2 = 32'd1; r0op = alu_add;
      r1d1 = 32'd9; r1d2 = 32'd4; r1op = alu_sub;
      req0_valid = 1'b1; req1_valid = 1'b1;
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      #1;
      chk1("tie1_rr_ready0", rr_rdy0, 1'b1);
      chk1("tie1_rr_ready1", rr_rdy1, 1'b0);
      chk1("tie1_fx_ready0", fx_rdy0, 1'b1);
      step();
      chk1("tie1_exec_ready0", rr_rdy0, 1'b0);
      chk1("tie1_exec_ready1", rr_rdy1, 1'b0);
      chk1("tie1_exec_busy", rr_busy, 1'b1);
      step();
      chk1("tie1_rsp0_valid", rr_v0, 1'b1);
      chkw("tie1_result", rr_res, 32'd2);
      chk1("tie1_fx_rsp1_valid", fx_v1, 1'b0);
      step();
      chk1("tie2_rr_ready1", rr_rdy1, 1'b1);
      chk1("tie2_rr_ready0", rr_rdy0, 1'b0);
      chk1("tie2_fx_ready0", fx_rdy0, 1'b1);
      chk1("tie2_fx_ready1", fx_rdy1, 1'b0);
      step();
      step();
      chk1("tie2_rsp1_valid", rr_v1, 1'b1);
      chk1("tie2_rsp0_valid", rr_v0, 1'b0);
      chkw("tie2_result", rr_res, 32'd5);
      chk1("tie2_fx_rsp0_valid", fx_v0, 1'b1);
      chk1("tie2_fx_rsp1_valid", fx_v1, 1'b0);
      chkw("tie2_fx_result", fx_res, 32'd2);
      step();
      chk1("tie3_rr_ready0", rr_rdy0, 1'b1);
      chk1("tie3_rr_ready1", rr_rdy1, 1'b0);
      chk1("tie3_fx_ready0", fx_rdy0, 1'b1);
      step();
      step();
      chk1("tie3_rsp0_valid", rr_v0, 1'b1);
      chkw("tie3_result", rr_res, 32'd2);
      chk1("tie3_fx_rsp1_valid", fx_v1, 1'b0);
      req0_valid = 1'b0; req1_valid = 1'b0;
      step();
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      chk1("tie_done_busy", rr_busy, 1'b0);
      chk1("tie_done_fx_busy", fx_busy, 1'b0);

      // single request 5+3, operands disturbed after acceptance
      r0d1 = 32'd5; r0d2 = 32'd3; r0op = alu_add;
      req0_valid = 1'b1;
      #1;
      chk1("single_ready0", rr_rdy0, 1'b1);
      chk1("single_ready1", rr_rdy1, 1'b0);
      step();
      req0_valid = 1'b0;
      r0d1 = 32'd99; r0d2 = 32'd99; r0op = alu_sub;
      chkw("single_alu_data1", rr_a, 32'd5);
      chk1("single_exec_rsp0", rr_v0, 1'b0);
      step();
      chk1("single_rsp0_valid", rr_v0, 1'b1);
      chk1("single_rsp1_valid", rr_v1, 1'b0);
      chkw("single_result", rr_res, 32'd8);
      rsp1_ready = 1'b1;
      step();
      chk1("single_nonowner_ready", rr_v0, 1'b1);
      rsp1_ready = 1'b0; rsp0_ready = 1'b1;
      step();
      rsp0_ready = 1'b0;
      chk1("single_idle_busy", rr_busy, 1'b0);
      chk1("single_idle_rsp0", rr_v0, 1'b0);

      // busy stall: req1 7-2, busy high for 4 EXEC cycles
      r1d1 = 32'd7; r1d2 = 32'd2; r1op = alu_sub;
      req1_valid = 1'b1;
      alu_busy = 1'b1;
      #1;
      chk1("stall_ready1", rr_rdy1, 1'b1);
      step();
      req1_valid = 1'b0;
      r1d1 = 32'd0;
      for (int i = 0; i < 4; i++) begin
         step();
         chk1("stall_busy", rr_busy, 1'b1);
         chk1("stall_rsp1_valid", rr_v1, 1'b0);
         chkw("stall_alu_data1", rr_a, 32'd7);
         chkw("stall_alu_data2", rr_b, 32'd2);
         chkw("stall_alu_op", 32'(rr_op), 32'(alu_sub));
      end
      alu_busy = 1'b0;
      step();
      chk1("stall_rsp1_valid_at5", rr_v1, 1'b1);
      chkw("stall_result", rr_res, 32'd5);

      // backpressure on rsp1 with req0 waiting
      r0d1 = 32'd2; r0d2 = 32'd2; r0op = alu_add;
      req0_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         chk1("bp_rsp1_valid", rr_v1, 1'b1);
         chkw("bp_result", rr_res, 32'd5);
         chk1("bp_ready0", rr_rdy0, 1'b0);
      end
      rsp1_ready = 1'b1;
      step();
      rsp1_ready = 1'b0;
      chk1("bp_release_ready0", rr_rdy0, 1'b1);
      chk1("bp_release_rsp1", rr_v1, 1'b0);
      step();
      req0_valid = 1'b0;
      step();
      chk1("bp_next_rsp0_valid", rr_v0, 1'b1);
      chkw("bp_next_result", rr_res, 32'd4);
      rsp0_ready = 1'b1;
      step();
      rsp0_ready = 1'b0;

      // unsupported opcode passes through; ALU returns zero
      r0d1 = 32'd3; r0d2 = 32'd4; r0op = aluop_t'(4'hF);
      req0_valid = 1'b1;
      step();
      req0_valid = 1'b0;
      chkw("unsup_alu_op", 32'(rr_op), 32'hF);
      step();
      chk1("unsup_rsp0_valid", rr_v0, 1'b1);
      chkw("unsup_result", rr_res, 32'd0);
      rsp0_ready = 1'b1;
      step();
      rsp0_ready = 1'b0;

      // reset while in EXEC; req0 owns so an unreset last_grant would favour req1
      r0d1 = 32'd10; r0d2 = 32'd1; r0op = alu_sub;
      req0_valid = 1'b1;
      step();
      req0_valid = 1'b0;
      chk1("mid_exec_busy", rr_busy, 1'b1);
      rst_n = 1'b0;
      #1;
      chk1("mid_rst_busy_low", rr_busy, 1'b0);
      step();
      rst_n = 1'b1;
      #1;
      chk1("mid_after_busy", rr_busy, 1'b0);
      chk1("mid_after_rsp0", rr_v0, 1'b0);
      chk1("mid_after_rsp1", rr_v1, 1'b0);
      chkw("mid_after_result", rr_res, 32'd0);
      chkw("mid_after_alu_data1", rr_a, 32'd0);
      step();
      chk1("mid_idle_rsp0", rr_v0, 1'b0);
      r1d1 = 32'd9; r1d2 = 32'd4; r1op = alu_sub;
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      chk1("mid_tie_ready0", rr_rdy0, 1'b1);
      chk1("mid_tie_ready1", rr_rdy1, 1'b0);
      req0_valid = 1'b0; req1_valid = 1'b0;
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_arb.md
ALU_ARB -- requirements
Module: alu_arb

Interface
REQ-001 Parameter FIXED_PRIO, default 0; 0 = round-robin between requesters, 1 = requester 0 always wins.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; synchronous, active-low.
REQ-004 req0_valid_i / req1_valid_i  input  1 each  requester N has an operation pending.
REQ-005 req0_ready_o / req1_ready_o  output  1 each  arbiter accepts requester N this cycle.
REQ-006 req0_data1_i, req0_data2_i, req1_data1_i, req1_data2_i  input  word each  operands.
REQ-007 req0_op_i / req1_op_i  input  aluop each  operation.
REQ-008 rsp0_valid_o / rsp1_valid_o  output  1 each  result for requester N is held.
REQ-009 rsp0_ready_i / rsp1_ready_i  input  1 each  requester N consumes the result.
REQ-010 rsp_result_o  output  word  registered result, shared by both response channels.
REQ-011 alu_data1_o, alu_data2_o  output  word  operands to the shared ALU.
REQ-012 alu_op_o  output  aluop  operation to the ALU.
REQ-013 alu_result_i  input  word  ALU result (combinational from ALU inputs).
REQ-014 alu_busy_i  input  1  ALU not yet done; result invalid while high.
REQ-015 arb_busy_o  output  1  high whenever state is not IDLE.

Function
REQ-016 FSM states IDLE, EXEC, RESP; transitions only on the clock edge.
REQ-017 IDLE: grant is combinational from the valids; reqN_ready_o = 1 only for the granted requester; both readys are 0 in EXEC and RESP.
REQ-018 Handshake: accept on the edge where reqN_valid_i & reqN_ready_o = 1; latch operands, op and owner id; go to EXEC.
REQ-019 Grant with a single valid: grant that requester regardless of mode.
REQ-020 Grant with both valid, FIXED_PRIO=0: grant the requester not recorded in last_grant; last_grant updates on every accept.
REQ-021 Grant with both valid, FIXED_PRIO=1: grant requester 0.
REQ-022 ALU drive: alu_data1_o, alu_data2_o and alu_op_o come from the latched registers in all states, so they are stable throughout EXEC.
REQ-023 EXEC: if alu_busy_i = 0, capture alu_result_i into rsp_result_o and go to RESP; else stay in EXEC without limit.
REQ-024 RESP: rspN_valid_o = 1 for the owner only; rsp_result_o is stable; on rspN_ready_i = 1 go to IDLE.
REQ-025 rspN_ready_i for a non-owner, or outside RESP, is ignored.
REQ-026 Latency: response valid 1 cycle after accept when busy is low; add 1 cycle per busy cycle. Throughput is at most 1 operation per 3 cycles.
REQ-027 A request that drops valid before acceptance is not remembered. Operands changing after acceptance have no effect.
REQ-028 Unsupported aluop values are passed through unchanged; the arbiter returns whatever the ALU produces (ZeroWord).

Reset
REQ-029 On rst_n = 0 at a clock edge, the block SHALL enter IDLE, from any state including mid-EXEC/RESP, and drop the in-flight operation with no response.
REQ-030 Reset values: operand registers `ZeroWord; op register alu_add; rsp_result_o `ZeroWord; owner 0; last_grant 1 (requester 0 wins the first tie).
REQ-031 Output values during and right after reset: all ready and valid outputs 0, arb_busy_o 0.

Structure
REQ-032 Arbiter state enum (arb_state_e: IDLE, EXEC, RESP) SHALL live in the shared defines package; the existing word and aluop types and `ZeroWord are reused.
REQ-033 Two-way grant logic SHALL be a sub-module alu_rr_grant (inputs: valids, last_grant, FIXED_PRIO; output: one-hot grant).

Verification
REQ-034 Single request, FIXED_PRIO=0:
- stimulus: req0 {5, 3, alu_add}, busy 0.
- response: accepted cycle T; rsp0_valid_o at T+1 with result 8; back in IDLE the cycle after rsp0_ready_i.
REQ-035 Simultaneous requests:
- stimulus: req0 alu_add 1+1 and req1 alu_sub 9-4, both held.
- response: req0 granted first (result 2), then req1 (result 5); a third tie grants req0 again.
REQ-036 FIXED_PRIO=1 with both requesters held valid:
- response: req0 granted every time; req1 is never accepted.
REQ-037 Busy stall:
- stimulus: alu_busy_i high for 4 cycles in EXEC.
- response: state stays EXEC; response valid 5 cycles after accept; alu outputs stable throughout.
REQ-038 Response backpressure:
- stimulus: rsp1_ready_i held low 10 cycles; req0 valid throughout.
- response: rsp1_valid_o and rsp_result_o stable; req0_ready_o stays 0 until consumption.
REQ-039 Reset mid-operation:
- stimulus: rst_n low during EXEC.
- response: next cycle IDLE, no rsp valid, rsp_result_o = 0, the next tie goes to req0.
